// File: rtl/fb_writer_pkg.sv
// Shared constants for the framebuffer writer: default geometry and FSM state encoding.
package fb_writer_pkg;
  localparam int A_DEF     = 12;
  localparam int D_DEF     = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO for queued framebuffer writes; exposes the head and the entry behind it
// so the writer can preload its registered RAM outputs one cycle ahead.
module fb_wr_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head,
  output logic [W-1:0]                 head2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic          do_push, do_pop;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign head       = mem[rd_ptr];
  assign head2      = mem[rd_ptr_inc];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: queues host pixel writes or fills the whole buffer, and only drives
// the RAM during blanking (display_on=0).
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int A     = A_DEF,
  parameter int D     = D_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         display_on,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [A-1:0] req_addr,
  input  logic [D-1:0] req_data,
  input  logic         fill_start,
  input  logic [D-1:0] fill_value,
  output logic         busy,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_wdata
);
  localparam int CW = $clog2(DEPTH+1);

  logic [1:0]     state;
  logic [A-1:0]   fill_cnt;
  logic [CW-1:0]  cnt;
  logic           full, empty, push, pop, fill_go;
  logic [A+D-1:0] head, head2, nxt;

  assign req_ready = !full && (state != ST_FILL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == ST_WRITE) && !display_on;
  assign ram_we    = ((state == ST_WRITE) || (state == ST_FILL)) && !display_on;
  assign busy      = (cnt != '0) || (state == ST_FILL);
  assign fill_go   = (state == ST_IDLE) && fill_start && empty && !push;

  fb_wr_fifo #(.W(A+D), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({req_addr, req_data}),
    .head  (head),
    .head2 (head2),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  // Entry that will sit at the FIFO head after this edge, so the RAM outputs are ready one cycle after acceptance
  always_comb begin
    nxt = {ram_addr, ram_wdata};
    if (pop) begin
      if (cnt > CW'(1)) nxt = head2;
      else if (push)    nxt = {req_addr, req_data};
    end else if (!empty) begin
      nxt = head;
    end else if (push) begin
      nxt = {req_addr, req_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push || !empty) begin
            state <= ST_WRITE;
          end else if (fill_go) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
          end
        end
        ST_WRITE: begin
          if (pop && (cnt == CW'(1)) && !push) state <= ST_IDLE;
        end
        ST_FILL: begin
          if (ram_we) begin
            if (fill_cnt == '1) state <= ST_IDLE;
            else                fill_cnt <= fill_cnt + A'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // During a fill ram_wdata keeps the value latched at fill_start
      if (state == ST_FILL) begin
        if (ram_we && (fill_cnt != '1)) ram_addr <= fill_cnt + A'(1);
      end else if (fill_go) begin
        ram_addr  <= '0;
        ram_wdata <= fill_value;
      end else begin
        {ram_addr, ram_wdata} <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus a randomized queue-model run.
module tb_fb_writer;
  localparam int A = 12;
  localparam int D = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0, reset = 1'b0, display_on = 1'b0;
  logic         req_valid = 1'b0, fill_start = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [D-1:0] req_data = '0, fill_value = '0;
  logic         req_ready, busy, ram_we;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_wdata;
  int tests = 0, fails = 0;

  typedef struct packed { logic [A-1:0] a; logic [D-1:0] d; } wr_t;
  wr_t mq[$];

  fb_writer #(.A(A), .D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .display_on(display_on), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .fill_start(fill_start), .fill_value(fill_value), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if ({ram_we, busy, ram_addr, ram_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_state: we=%b busy=%b addr=%h data=%h, expected all 0", ram_we, busy, ram_addr, ram_wdata);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_single();
    display_on = 1'b0; req_valid = 1'b1; req_addr = 12'h123; req_data = 8'h5A; #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0; #1;
    tests++;
    if ({ram_we, busy, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'h123, 8'h5A}) begin
      fails++;
      $display("FAIL single_write: we=%b busy=%b addr=%h data=%h, expected 1 1 123 5a", ram_we, busy, ram_addr, ram_wdata);
    end
    tick();
    tests++;
    if ({ram_we, busy} !== 2'b00) begin fails++; $display("FAIL single_done: we=%b busy=%b expected 0 0", ram_we, busy); end
  endtask

  task automatic test_stall();
    wr_t e;
    logic exp_rdy;
    mq.delete();
    display_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.a = A'($urandom); e.d = D'($urandom);
      req_valid = 1'b1; req_addr = e.a; req_data = e.d; #1;
      exp_rdy = (i < DEPTH);
      tests++;
      if (req_ready !== exp_rdy || ram_we !== 1'b0) begin
        fails++;
        $display("FAIL stall_push%0d: ready=%b we=%b expected ready=%b we=0", i, req_ready, ram_we, exp_rdy);
      end
      if (exp_rdy) mq.push_back(e);
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (ram_we !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL stall_hold: we=%b busy=%b expected 0 1", ram_we, busy); end
    display_on = 1'b0; #1;
    for (int i = 0; i < DEPTH; i++) begin
      e = mq.pop_front();
      tests++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, e.a, e.d}) begin
        fails++;
        $display("FAIL stall_drain%0d: we=%b addr=%h data=%h expected 1 %h %h", i, ram_we, ram_addr, ram_wdata, e.a, e.d);
      end
      tick();
    end
    tests++;
    if ({ram_we, busy} !== 2'b00) begin fails++; $display("FAIL stall_idle: we=%b busy=%b expected 0 0", ram_we, busy); end
  endtask

  task automatic test_back_to_back();
    int dpct;
    logic exp_we, exp_rdy, exp_busy;
    wr_t e, h;
    mq.delete();
    for (int cyc = 0; cyc < 420; cyc++) begin
      case ((cyc / 50) % 4)
        0: dpct = 0;
        1: dpct = 70;
        2: dpct = 20;
        default: dpct = 95;
      endcase
      e.a = A'($urandom); e.d = D'($urandom);
      display_on = (cyc < 400) && ($urandom_range(0, 99) < dpct);
      req_valid  = (cyc < 400) && ($urandom_range(0, 9) < 7);
      req_addr = e.a; req_data = e.d;
      @(negedge clk);
      exp_rdy  = (mq.size() < DEPTH);
      exp_busy = (mq.size() > 0);
      exp_we   = exp_busy && !display_on;
      tests++;
      if (req_ready !== exp_rdy || ram_we !== exp_we || busy !== exp_busy) begin
        fails++;
        $display("FAIL rand_ctrl cyc%0d: ready=%b we=%b busy=%b expected %b %b %b", cyc, req_ready, ram_we, busy, exp_rdy, exp_we, exp_busy);
      end
      if (exp_we) begin
        h = mq.pop_front();
        tests++;
        if ({ram_addr, ram_wdata} !== h) begin
          fails++;
          $display("FAIL rand_data cyc%0d: addr=%h data=%h expected %h %h", cyc, ram_addr, ram_wdata, h.a, h.d);
        end
      end
      if (req_valid && exp_rdy) mq.push_back(e);
      tick();
    end
    tests++;
    if (mq.size() != 0) begin fails++; $display("FAIL rand_drain: %0d writes missing, expected 0", mq.size()); end
  endtask

  task automatic test_fill(input logic [D-1:0] val, input bit toggle);
    int bad = 0, nwr = 0, cyc = 0;
    display_on = 1'b0; req_valid = 1'b0;
    fill_value = val; fill_start = 1'b1;
    tick();
    fill_start = 1'b0; fill_value = ~val;
    while (nwr < (1 << A) && cyc < 12000) begin
      if (toggle) display_on = ((cyc / 10) % 2) == 1;
      @(negedge clk);
      if (ram_we) begin
        if (display_on) bad++;
        if (ram_addr !== A'(nwr) || ram_wdata !== val) begin
          if (bad < 3) $display("note: fill write %0d at addr=%h data=%h", nwr, ram_addr, ram_wdata);
          bad++;
        end
        nwr++;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
      tick();
      cyc++;
    end
    tests++;
    if (nwr != (1 << A)) begin fails++; $display("FAIL fill_count toggle=%0d: %0d writes, expected %0d", toggle, nwr, 1 << A); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL fill_sequence toggle=%0d: %0d bad cycles, expected 0", toggle, bad); end
    display_on = 1'b0;
    tick();
    tests++;
    if ({ram_we, busy, req_ready} !== 3'b001) begin
      fails++;
      $display("FAIL fill_end toggle=%0d: we=%b busy=%b ready=%b expected 0 0 1", toggle, ram_we, busy, req_ready);
    end
  endtask

  task automatic test_fill_ignored();
    wr_t e;
    int nwr = 0;
    mq.delete();
    display_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e.a = A'($urandom); e.d = D'($urandom);
      req_valid = 1'b1; req_addr = e.a; req_data = e.d;
      mq.push_back(e);
      tick();
    end
    req_valid = 1'b0; fill_value = 8'hEE; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tests++;
    if ({busy, req_ready} !== 2'b11) begin fails++; $display("FAIL ign_state: busy=%b ready=%b expected 1 1", busy, req_ready); end
    display_on = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ram_we) begin
        e = (mq.size() > 0) ? mq.pop_front() : '0;
        tests++;
        if ({ram_addr, ram_wdata} !== e) begin
          fails++;
          $display("FAIL ign_write%0d: addr=%h data=%h expected %h %h", nwr, ram_addr, ram_wdata, e.a, e.d);
        end
        nwr++;
      end
      tick();
    end
    tests++;
    if (nwr != 2 || busy !== 1'b0) begin fails++; $display("FAIL ign_count: %0d writes busy=%b expected 2 0", nwr, busy); end
  endtask

  task automatic test_reset_midfill();
    bit found = 0;
    int nwr = 0;
    display_on = 1'b0; fill_value = 8'h3C; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 12'h400) found = 1;
      else tick();
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rst_reach: addr 400 seen=%0d expected 1", found); end
    #1 reset = 1'b0; #1;
    tests++;
    if ({ram_we, busy, ram_addr} !== '0) begin
      fails++;
      $display("FAIL rst_immediate: we=%b busy=%b addr=%h expected 0 0 000", ram_we, busy, ram_addr);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ram_we) nwr++;
      tick();
    end
    tests++;
    if (nwr != 0 || busy !== 1'b0) begin fails++; $display("FAIL rst_after: %0d writes busy=%b expected 0 0", nwr, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_fill(8'h07, 1'b0);
    test_fill(D'($urandom), 1'b1);
    test_fill_ignored();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
